// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state codes, default sizing
// and the prescaler width helper.
package timer_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int unsigned DEF_N   = 4;
  localparam int unsigned DEF_DIV = 1;

  // ceil(log2(v)), never less than 1 so a DIV=1 prescaler still has a bit
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned w;
    w = 0;
    while ((64'(1) << w) < 64'(v)) w++;
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_down_counter.sv
// N-bit synchronous down counter: clr forces all ones, load beats decrement.
module sync_down_counter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = q_q - N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '1;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/down_timer_ctrl.sv
// Programmable countdown timer: command-loaded down counter with prescaler,
// pause/abort, auto-reload, one-cycle terminal pulse and sticky done.
module down_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned N   = DEF_N,
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_load,
  input  logic         cmd_auto,
  input  logic         pause,
  input  logic         abort,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  localparam int unsigned    PW         = clog2_min1(DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

  logic [1:0]    state_q,  state_d;
  logic [PW-1:0] presc_q,  presc_d;
  logic [N-1:0]  reload_q, reload_d;
  logic          auto_q,   auto_d;
  logic          tc_q,     tc_d;

  logic          cnt_load;
  logic [N-1:0]  cnt_load_val;
  logic          cnt_en;
  logic [N-1:0]  cnt_q;

  sync_down_counter #(.N(N)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .q        (cnt_q)
  );

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    reload_d     = reload_q;
    auto_d       = auto_q;
    tc_d         = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = cmd_load;
    cnt_en       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cmd_valid) begin
          reload_d = cmd_load;
          auto_d   = cmd_auto;
          presc_d  = '0;
          cnt_load = 1'b1;
          // A zero one-shot load is already at terminal count
          if (cmd_load == '0 && !cmd_auto) begin
            tc_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (cnt_q > N'(1)) begin
              cnt_en = 1'b1;
            end else if (cnt_q == N'(1)) begin
              cnt_en = 1'b1;
              tc_d   = 1'b1;
              if (!auto_q) state_d = ST_DONE;
            end else begin
              // q==0 is only reachable in auto mode: reload from the held value
              cnt_load     = 1'b1;
              cnt_load_val = reload_q;
              tc_d         = (reload_q == '0);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      reload_q <= '0;
      auto_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      auto_q   <= auto_d;
      tc_q     <= tc_d;
    end
  end

  assign q         = cnt_q;
  assign tc        = tc_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Directed bench: a vector table against a DIV=1 timer, plus hand-written
// prescaler and mid-run clear sequences against a DIV=3 timer.
module tb_down_timer_ctrl;

  logic       clk;
  logic       clr;
  logic       cmd_valid;
  logic [3:0] cmd_load;
  logic       cmd_auto;
  logic       pause;
  logic       abort;

  logic       rdy1, tc1, busy1, done1;
  logic [3:0] q1;
  logic       rdy3, tc3, busy3, done3;
  logic [3:0] q3;

  int checks;
  int failures;

  down_timer_ctrl #(.N(4), .DIV(1)) dut1 (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_load(cmd_load), .cmd_auto(cmd_auto), .pause(pause), .abort(abort),
    .q(q1), .tc(tc1), .busy(busy1), .done(done1)
  );

  down_timer_ctrl #(.N(4), .DIV(3)) dut3 (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(rdy3),
    .cmd_load(cmd_load), .cmd_auto(cmd_auto), .pause(pause), .abort(abort),
    .q(q3), .tc(tc3), .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       valid;
    logic [3:0] load;
    logic       auto_m;
    logic       pause;
    logic       abort;
    logic [3:0] exp_q;
    logic       exp_tc;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int step, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic v, input logic [3:0] l,
                       input logic a, input logic p, input logic ab);
    clr = c; cmd_valid = v; cmd_load = l; cmd_auto = a; pause = p; abort = ab;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic c, input logic v, input logic [3:0] l, input logic a,
                     input logic p, input logic ab, input logic [3:0] eq,
                     input logic et, input logic eb, input logic ed, input logic er);
    vec_t t;
    t.clr = c; t.valid = v; t.load = l; t.auto_m = a; t.pause = p; t.abort = ab;
    t.exp_q = eq; t.exp_tc = et; t.exp_busy = eb; t.exp_done = ed; t.exp_ready = er;
    vecs.push_back(t);
  endtask

  task automatic chk3(input string tag, input int s, input logic [3:0] eq,
                      input logic et, input logic eb, input logic ed);
    chk({tag, "_q"},    s, int'(q3),    int'(eq));
    chk({tag, "_tc"},   s, int'(tc3),   int'(et));
    chk({tag, "_busy"}, s, int'(busy3), int'(eb));
    chk({tag, "_done"}, s, int'(done3), int'(ed));
  endtask

  logic [3:0] exp_q3[7];

  initial begin
    checks = 0;
    failures = 0;
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    //   clr valid load auto pause abort | q tc busy done ready
    // reset with noisy inputs; a command under clr is not accepted
    add(1, 1, 4'h7, 1, 1, 1,  4'hF, 0, 0, 0, 1);
    add(1, 1, 4'h7, 1, 1, 1,  4'hF, 0, 0, 0, 1);
    // one-shot L=3
    add(0, 1, 4'h3, 0, 0, 0,  4'h3, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h2, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h1, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h0, 1, 0, 1, 1);
    add(0, 0, 4'h0, 0, 1, 1,  4'h0, 0, 0, 1, 1);
    add(0, 0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 1, 1);
    // auto L=2, commands during RUN ignored, abort
    add(0, 1, 4'h2, 1, 0, 0,  4'h2, 0, 1, 0, 0);
    add(0, 1, 4'h9, 0, 0, 0,  4'h1, 0, 1, 0, 0);
    add(0, 1, 4'h9, 0, 0, 0,  4'h0, 1, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h2, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h1, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h0, 1, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h2, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 1,  4'h2, 0, 0, 0, 1);
    add(0, 0, 4'h0, 0, 0, 1,  4'h2, 0, 0, 0, 1);
    // pause then abort-with-pause, L=5
    add(0, 1, 4'h5, 0, 0, 0,  4'h5, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h4, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h3, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 1, 0,  4'h3, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 1, 0,  4'h3, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 1, 0,  4'h3, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 1, 0,  4'h3, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h2, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 1, 1,  4'h2, 0, 0, 0, 1);
    // zero load: one-shot goes straight to DONE, auto pulses every tick
    add(0, 1, 4'h0, 0, 0, 0,  4'h0, 1, 0, 1, 1);
    add(0, 0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 1, 1);
    add(0, 1, 4'h0, 1, 0, 0,  4'h0, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h0, 1, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h0, 1, 1, 0, 0);
    add(0, 0, 4'h0, 0, 1, 0,  4'h0, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'h0, 1, 1, 0, 0);
    // full-scale one-shot start value
    add(0, 0, 4'h0, 0, 0, 1,  4'h0, 0, 0, 0, 1);
    add(0, 1, 4'hF, 0, 0, 0,  4'hF, 0, 1, 0, 0);
    add(0, 0, 4'h0, 0, 0, 0,  4'hE, 0, 1, 0, 0);
    add(1, 0, 4'h0, 0, 0, 0,  4'hF, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].valid, vecs[i].load, vecs[i].auto_m,
            vecs[i].pause, vecs[i].abort);
      step();
      chk("q",     i, int'(q1),    int'(vecs[i].exp_q));
      chk("tc",    i, int'(tc1),   int'(vecs[i].exp_tc));
      chk("busy",  i, int'(busy1), int'(vecs[i].exp_busy));
      chk("done",  i, int'(done1), int'(vecs[i].exp_done));
      chk("ready", i, int'(rdy1),  int'(vecs[i].exp_ready));
    end

    // DIV=3 one-shot L=2: each value lasts three cycles, tc with q reaching 0
    exp_q3[0] = 4'h2; exp_q3[1] = 4'h2; exp_q3[2] = 4'h2;
    exp_q3[3] = 4'h1; exp_q3[4] = 4'h1; exp_q3[5] = 4'h1;
    exp_q3[6] = 4'h0;
    drive(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 7; s++) begin
      step();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk3("p3", s, exp_q3[s], (s == 6), (s != 6), (s == 6));
    end
    step();
    chk3("p3_hold", 0, 4'h0, 1'b0, 1'b0, 1'b1);

    // DIV=3 clear mid-run while q=1
    drive(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      step();
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk3("c3", s, exp_q3[s], 1'b0, 1'b1, 1'b0);
    end
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk3("c3_clr", 0, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("c3_ready", 0, int'(rdy3), 1);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk3("c3_after", 0, 4'hF, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
